// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : core_sequencer
// Purpose  : Multi-cycle fetch/decode/execute/mem/writeback control FSM with
//            free-run, single-step and fault-halt modes.
// Revision : 1.0 - initial release
// ============================================================================
module core_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        run_i,
    input  logic        step_mode_i,
    input  logic        step_i,
    input  logic        illegal_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic        reg_wr_sig_i,
    input  logic        imem_ack_i,
    input  logic        dmem_ack_i,
    output logic        imem_req_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic        reg_we_o,
    output logic        busy_o,
    output logic        fault_o,
    output logic [1:0]  fault_code_o,
    output logic [2:0]  state_o,
    output logic [31:0] instr_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_PAUSE     = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CODE_ILLEGAL = 2'd1;
    localparam logic [1:0] CODE_IMEM_TO = 2'd2;
    localparam logic [1:0] CODE_DMEM_TO = 2'd3;

    state_t      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic [1:0]  code_q, code_d;
    logic [31:0] cnt_q, cnt_d;
    logic        w_expired;

    assign w_expired = (wait_q == WAIT_LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        code_d     = code_q;
        cnt_d      = cnt_q;
        imem_req_o = 1'b0;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        ir_we_o    = 1'b0;
        pc_we_o    = 1'b0;
        reg_we_o   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                imem_req_o = 1'b1;
                // An ack in the expiry cycle still wins over the timeout.
                if (imem_ack_i) begin
                    ir_we_o = 1'b1;
                    state_d = S_DECODE;
                end else if (w_expired) begin
                    state_d = S_FAULT;
                    code_d  = CODE_IMEM_TO;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_DECODE: begin
                if (illegal_i) begin
                    state_d = S_FAULT;
                    code_d  = CODE_ILLEGAL;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (is_load_i || is_store_i) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = is_store_i;
                if (dmem_ack_i) begin
                    state_d = S_WRITEBACK;
                end else if (w_expired) begin
                    state_d = S_FAULT;
                    code_d  = CODE_DMEM_TO;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_WRITEBACK: begin
                pc_we_o  = 1'b1;
                reg_we_o = reg_wr_sig_i & ~is_store_i;
                cnt_d    = cnt_q + 32'd1;
                if (!run_i) begin
                    state_d = S_IDLE;
                end else if (step_mode_i) begin
                    state_d = S_PAUSE;
                end else begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_PAUSE: begin
                if (!run_i) begin
                    state_d = S_IDLE;
                end else if (step_i) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state_o      = state_q;
    assign fault_o      = (state_q == S_FAULT);
    assign fault_code_o = code_q;
    assign instr_cnt_o  = cnt_q;
    assign busy_o       = (state_q != S_IDLE) && (state_q != S_PAUSE) && (state_q != S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_sequencer
// Purpose  : Scoreboard bench for core_sequencer with TIMEOUT_CYCLES=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_sequencer;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DEC = 3'd2, ST_EXE = 3'd3,
                           ST_MEM  = 3'd4, ST_WB    = 3'd5, ST_PAUSE = 3'd6, ST_FAULT = 3'd7;

    // {imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we}
    localparam logic [5:0] O_NONE  = 6'b000000;
    localparam logic [5:0] O_IREQ  = 6'b100000;
    localparam logic [5:0] O_IR    = 6'b100100;
    localparam logic [5:0] O_DREQ  = 6'b010000;
    localparam logic [5:0] O_DREQW = 6'b011000;
    localparam logic [5:0] O_PC    = 6'b000010;
    localparam logic [5:0] O_PCREG = 6'b000011;

    logic        clk = 1'b0;
    logic        rst, run, step_mode, step, illegal, is_load, is_store, reg_wr, imem_ack, dmem_ack;
    logic        imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, reg_we_o, busy_o, fault_o;
    logic [1:0]  fault_code_o;
    logic [2:0]  state_o;
    logic [31:0] instr_cnt_o;

    logic [1:0]  exp_code;
    logic [12:0] sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    core_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .run_i        (run),
        .step_mode_i  (step_mode),
        .step_i       (step),
        .illegal_i    (illegal),
        .is_load_i    (is_load),
        .is_store_i   (is_store),
        .reg_wr_sig_i (reg_wr),
        .imem_ack_i   (imem_ack),
        .dmem_ack_i   (dmem_ack),
        .imem_req_o   (imem_req_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .ir_we_o      (ir_we_o),
        .pc_we_o      (pc_we_o),
        .reg_we_o     (reg_we_o),
        .busy_o       (busy_o),
        .fault_o      (fault_o),
        .fault_code_o (fault_code_o),
        .state_o      (state_o),
        .instr_cnt_o  (instr_cnt_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already applied; expected view is
    // {state, outs, busy, fault, code}, sampled 1 ns after the falling edge.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [5:0] o);
        logic [12:0] got;
        sb_q.push_back({st, o, (st != ST_IDLE && st != ST_PAUSE && st != ST_FAULT),
                        (st == ST_FAULT), exp_code});
        #1;
        got = {state_o, imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, reg_we_o,
               busy_o, fault_o, fault_code_o};
        check_eq(tag, 32'(got), 32'(sb_q.pop_front()));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        exp_code = 2'd0;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; run = 1'b0; step_mode = 1'b0; step = 1'b0; illegal = 1'b0;
        is_load = 1'b0; is_store = 1'b0; reg_wr = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        exp_code = 2'd0;
        repeat (2) @(negedge clk);

        // Reset and one free-running ALU instruction
        cyc("reset_state", ST_IDLE, O_NONE);
        check_eq("reset_cnt", instr_cnt_o, 32'd0);
        rst = 1'b0; run = 1'b1; reg_wr = 1'b1; step = 1'b1;
        cyc("alu_idle", ST_IDLE, O_NONE);
        imem_ack = 1'b1;
        cyc("alu_fetch", ST_FETCH, O_IR);
        imem_ack = 1'b0; dmem_ack = 1'b1;
        cyc("alu_decode", ST_DEC, O_NONE);
        cyc("alu_execute", ST_EXE, O_NONE);
        dmem_ack = 1'b0; step = 1'b0;
        cyc("alu_wb", ST_WB, O_PCREG);
        is_store = 1'b1;
        cyc("alu_next_fetch", ST_FETCH, O_IREQ);
        check_eq("alu_cnt", instr_cnt_o, 32'd1);

        // Store with three dmem wait cycles
        imem_ack = 1'b1;
        cyc("st_fetch", ST_FETCH, O_IR);
        imem_ack = 1'b0;
        cyc("st_decode", ST_DEC, O_NONE);
        cyc("st_execute", ST_EXE, O_NONE);
        for (int i = 0; i < 3; i++) cyc($sformatf("st_mem_wait%0d", i), ST_MEM, O_DREQW);
        dmem_ack = 1'b1;
        cyc("st_mem_ack", ST_MEM, O_DREQW);
        dmem_ack = 1'b0;
        cyc("st_wb", ST_WB, O_PC);
        is_store = 1'b0; step_mode = 1'b1;
        cyc("st_after", ST_FETCH, O_IREQ);
        check_eq("st_cnt", instr_cnt_o, 32'd2);

        // Single step
        imem_ack = 1'b1;
        cyc("ss_fetch", ST_FETCH, O_IR);
        imem_ack = 1'b0;
        cyc("ss_decode", ST_DEC, O_NONE);
        cyc("ss_execute", ST_EXE, O_NONE);
        cyc("ss_wb", ST_WB, O_PCREG);
        imem_ack = 1'b1;
        for (int i = 0; i < 10; i++) cyc($sformatf("ss_pause%0d", i), ST_PAUSE, O_NONE);
        imem_ack = 1'b0; step = 1'b1;
        cyc("ss_pause_step", ST_PAUSE, O_NONE);
        step = 1'b0; imem_ack = 1'b1;
        cyc("ss_refetch", ST_FETCH, O_IR);
        imem_ack = 1'b0;
        cyc("ss2_decode", ST_DEC, O_NONE);
        cyc("ss2_execute", ST_EXE, O_NONE);
        cyc("ss2_wb", ST_WB, O_PCREG);
        run = 1'b0; step = 1'b1;
        cyc("ss_pause_stop", ST_PAUSE, O_NONE);
        step = 1'b0;
        cyc("ss_idle", ST_IDLE, O_NONE);
        check_eq("ss_cnt", instr_cnt_o, 32'd4);

        // Illegal instruction halts until reset
        run = 1'b1; step_mode = 1'b0;
        cyc("ill_idle", ST_IDLE, O_NONE);
        imem_ack = 1'b1;
        cyc("ill_fetch", ST_FETCH, O_IR);
        imem_ack = 1'b0; illegal = 1'b1;
        cyc("ill_decode", ST_DEC, O_NONE);
        exp_code = 2'd1;
        for (int i = 0; i < 6; i++) begin
            imem_ack = i[0]; dmem_ack = ~i[0]; step = i[1];
            cyc($sformatf("ill_fault%0d", i), ST_FAULT, O_NONE);
        end
        imem_ack = 1'b0; dmem_ack = 1'b0; step = 1'b0; illegal = 1'b0;
        do_reset();
        cyc("ill_cleared", ST_IDLE, O_NONE);

        // imem timeout: four unacked fetch cycles
        for (int i = 0; i < 4; i++) cyc($sformatf("ito_fetch%0d", i), ST_FETCH, O_IREQ);
        exp_code = 2'd2;
        cyc("ito_fault", ST_FAULT, O_NONE);
        do_reset();
        cyc("ito_idle", ST_IDLE, O_NONE);

        // Ack in the expiry cycle wins, then dmem timeout on a load
        for (int i = 0; i < 3; i++) cyc($sformatf("late_fetch%0d", i), ST_FETCH, O_IREQ);
        imem_ack = 1'b1;
        cyc("late_fetch_ack", ST_FETCH, O_IR);
        imem_ack = 1'b0; is_load = 1'b1;
        cyc("late_decode", ST_DEC, O_NONE);
        cyc("ld_execute", ST_EXE, O_NONE);
        for (int i = 0; i < 4; i++) cyc($sformatf("dto_mem%0d", i), ST_MEM, O_DREQ);
        exp_code = 2'd3;
        cyc("dto_fault", ST_FAULT, O_NONE);
        is_load = 1'b0;
        do_reset();
        cyc("dto_idle", ST_IDLE, O_NONE);

        // Counter wrap from all-ones
        cyc("wrap_fetch0", ST_FETCH, O_IREQ);
        force dut.cnt_q = 32'hFFFF_FFFF;
        cyc("wrap_fetch1", ST_FETCH, O_IREQ);
        release dut.cnt_q;
        check_eq("wrap_pre", instr_cnt_o, 32'hFFFF_FFFF);
        imem_ack = 1'b1;
        cyc("wrap_fetch_ack", ST_FETCH, O_IR);
        imem_ack = 1'b0;
        cyc("wrap_decode", ST_DEC, O_NONE);
        cyc("wrap_execute", ST_EXE, O_NONE);
        is_store = 1'b1;
        cyc("wrap_wb", ST_WB, O_PC);
        check_eq("wrap_post", instr_cnt_o, 32'd0);

        // Reset in the middle of a store's MEM phase
        imem_ack = 1'b1;
        cyc("rm_fetch", ST_FETCH, O_IR);
        imem_ack = 1'b0;
        cyc("rm_decode", ST_DEC, O_NONE);
        cyc("rm_execute", ST_EXE, O_NONE);
        cyc("rm_mem0", ST_MEM, O_DREQW);
        rst = 1'b1;
        cyc("rm_mem1", ST_MEM, O_DREQW);
        rst = 1'b0; run = 1'b0;
        cyc("rm_after_reset", ST_IDLE, O_NONE);
        check_eq("rm_cnt", instr_cnt_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
